// File: rtl/block_ram_arbiter_if.sv
// block_ram_arbiter_if: requester handshake, response and RAM port bundle for block_ram_arbiter.
// slave is the arbiter side; master is the environment (requesters plus the RAM).
interface block_ram_arbiter_if #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int PORT_COUNT    = 4
);
    logic [PORT_COUNT-1:0]               req_valid;
    logic [PORT_COUNT-1:0]               req_write;
    logic [PORT_COUNT*ADDRESS_WIDTH-1:0] req_address;
    logic [PORT_COUNT*WORD_WIDTH-1:0]    req_write_data;
    logic [PORT_COUNT-1:0]               req_ready;
    logic [PORT_COUNT-1:0]               resp_valid;
    logic [WORD_WIDTH-1:0]               resp_data;
    logic [ADDRESS_WIDTH-1:0]            ram_write_address;
    logic                                ram_write;
    logic [WORD_WIDTH-1:0]               ram_write_data;
    logic [ADDRESS_WIDTH-1:0]            ram_read_address;
    logic                                ram_read;
    logic [WORD_WIDTH-1:0]               ram_read_data;

    modport slave (
        input  req_valid, req_write, req_address, req_write_data, ram_read_data,
        output req_ready, resp_valid, resp_data,
        output ram_write_address, ram_write, ram_write_data, ram_read_address, ram_read
    );

    modport master (
        output req_valid, req_write, req_address, req_write_data, ram_read_data,
        input  req_ready, resp_valid, resp_data,
        input  ram_write_address, ram_write, ram_write_data, ram_read_address, ram_read
    );
endinterface

// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter: shares one simple dual-port RAM among requesters using independent
// round-robin write and read arbiters; read data returns to its requester one cycle later.
module block_ram_arbiter #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int PORT_COUNT    = 4
) (
    input logic clock,
    input logic reset_n,
    block_ram_arbiter_if.slave bus
);
    localparam int PW = PORT_COUNT > 1 ? $clog2(PORT_COUNT) : 1;

    logic [PW-1:0]         r_write_ptr;
    logic [PW-1:0]         r_read_ptr;
    logic [PORT_COUNT-1:0] r_resp_valid;
    logic [PORT_COUNT-1:0] w_write_req;
    logic [PORT_COUNT-1:0] w_read_req;
    logic [PORT_COUNT-1:0] w_write_onehot;
    logic [PORT_COUNT-1:0] w_read_onehot;
    logic [PW:0]           w_write_pick;
    logic [PW:0]           w_read_pick;
    logic                  w_write_grant;
    logic                  w_read_grant;
    logic [PW-1:0]         w_write_idx;
    logic [PW-1:0]         w_read_idx;

    // Scan offsets downward so the smallest offset from the pointer is the final hit.
    function automatic logic [PW:0] rr_pick(input logic [PORT_COUNT-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int j;
        res = '0;
        for (int k = PORT_COUNT - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % PORT_COUNT;
            if (req[j]) res = {1'b1, PW'(j)};
        end
        return res;
    endfunction

    // Gating the requests with reset_n keeps every grant and RAM strobe low during reset.
    assign w_write_req  = bus.req_valid & bus.req_write & {PORT_COUNT{reset_n}};
    assign w_read_req   = bus.req_valid & ~bus.req_write & {PORT_COUNT{reset_n}};
    assign w_write_pick = rr_pick(w_write_req, r_write_ptr);
    assign w_read_pick  = rr_pick(w_read_req, r_read_ptr);
    assign {w_write_grant, w_write_idx} = w_write_pick;
    assign {w_read_grant, w_read_idx}   = w_read_pick;

    assign w_write_onehot = w_write_grant ? PORT_COUNT'(1) << w_write_idx : '0;
    assign w_read_onehot  = w_read_grant ? PORT_COUNT'(1) << w_read_idx : '0;
    assign bus.req_ready  = w_write_onehot | w_read_onehot;

    assign bus.ram_write         = w_write_grant;
    assign bus.ram_write_address = w_write_grant ? bus.req_address[w_write_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
    assign bus.ram_write_data    = w_write_grant ? bus.req_write_data[w_write_idx*WORD_WIDTH +: WORD_WIDTH] : '0;
    assign bus.ram_read          = w_read_grant;
    assign bus.ram_read_address  = w_read_grant ? bus.req_address[w_read_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = bus.ram_read_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write_ptr  <= '0;
            r_read_ptr   <= '0;
            r_resp_valid <= '0;
        end else begin
            if (w_write_grant) r_write_ptr <= PW'((int'(w_write_idx) + 1) % PORT_COUNT);
            if (w_read_grant) r_read_ptr <= PW'((int'(w_read_idx) + 1) % PORT_COUNT);
            r_resp_valid <= w_read_onehot;
        end
    end
endmodule

// File: tb/tb_block_ram_arbiter.sv
// tb_block_ram_arbiter: directed scenarios plus a randomized run against a round-robin
// reference model; includes a behavioural RAM with read-during-write forwarding.
module tb_block_ram_arbiter;
    localparam int W = 32;
    localparam int A = 12;
    localparam int P = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    int checks = 0;
    int failures = 0;

    logic [P-1:0] v;
    logic [P-1:0] wr;
    logic [A-1:0] ad [P];
    logic [W-1:0] dt [P];
    logic [W-1:0] mem [0:(1<<A)-1];
    logic [W-1:0] ram_q;
    logic [W-1:0] ref_mem [16];

    always #5 clock = ~clock;

    block_ram_arbiter_if #(.WORD_WIDTH(W), .ADDRESS_WIDTH(A), .PORT_COUNT(P)) bus ();
    block_ram_arbiter #(.WORD_WIDTH(W), .ADDRESS_WIDTH(A), .PORT_COUNT(P)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    always @(posedge clock) begin
        if (bus.ram_write) mem[bus.ram_write_address] <= bus.ram_write_data;
        if (bus.ram_read)
            ram_q <= (bus.ram_write && bus.ram_write_address == bus.ram_read_address) ? bus.ram_write_data : mem[bus.ram_read_address];
    end
    assign bus.ram_read_data = ram_q;

    task automatic drive();
        bus.req_valid = v;
        bus.req_write = wr;
        for (int i = 0; i < P; i++) begin
            bus.req_address[i*A +: A] = ad[i];
            bus.req_write_data[i*W +: W] = dt[i];
        end
    endtask

    task automatic clear();
        v = '0;
        wr = '0;
        for (int i = 0; i < P; i++) begin
            ad[i] = '0;
            dt[i] = '0;
        end
        drive();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        clear();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear();
        #1 reset_n = 1'b0;
        v = '1;
        for (int i = 0; i < P; i++) begin
            ad[i] = A'(12'h300 + i);
            dt[i] = 32'hA000_0000 + i;
        end
        drive();
        @(negedge clock); #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.ram_read !== 1'b0) begin failures++; $display("FAIL reset_ram_read got=%b exp=0", bus.ram_read); end
        checks++; if (bus.ram_write !== 1'b0) begin failures++; $display("FAIL reset_ram_write got=%b exp=0", bus.ram_write); end
        checks++; if (bus.resp_valid !== 4'b0000) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0000", bus.resp_valid); end
        reset_n = 1'b1; #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL release_read_ready got=%b exp=0001", bus.req_ready); end
        checks++; if (bus.ram_read_address !== 12'h300) begin failures++; $display("FAIL release_read_addr got=%h exp=300", bus.ram_read_address); end
        wr = '1;
        drive(); #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL release_write_ready got=%b exp=0001", bus.req_ready); end
        checks++; if (bus.ram_write_data !== 32'hA000_0000) begin failures++; $display("FAIL release_write_data got=%h exp=a0000000", bus.ram_write_data); end
        clear();
        @(negedge clock);
    endtask

    task automatic test_single_port();
        do_reset();
        v[2] = 1'b1; wr[2] = 1'b1; ad[2] = 12'h010; dt[2] = 32'hDEADBEEF;
        drive(); #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_wr_ready got=%b exp=0100", bus.req_ready); end
        checks++; if ({bus.ram_write, bus.ram_read} !== 2'b10) begin failures++; $display("FAIL single_wr_strobes got=%b exp=10", {bus.ram_write, bus.ram_read}); end
        checks++; if (bus.ram_write_address !== 12'h010) begin failures++; $display("FAIL single_wr_addr got=%h exp=010", bus.ram_write_address); end
        checks++; if (bus.ram_write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_wr_data got=%h exp=deadbeef", bus.ram_write_data); end
        @(negedge clock);
        wr[2] = 1'b0;
        drive(); #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_rd_ready got=%b exp=0100", bus.req_ready); end
        checks++; if (bus.ram_read_address !== 12'h010) begin failures++; $display("FAIL single_rd_addr got=%h exp=010", bus.ram_read_address); end
        @(negedge clock);
        clear(); #1;
        checks++; if (bus.resp_valid !== 4'b0100) begin failures++; $display("FAIL single_resp_valid got=%b exp=0100", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_resp_data got=%h exp=deadbeef", bus.resp_data); end
        @(negedge clock);
    endtask

    task automatic test_round_robin();
        logic [W-1:0] rr_data [P];
        do_reset();
        v = '1; wr = '1;
        for (int i = 0; i < P; i++) begin
            rr_data[i] = $urandom;
            ad[i] = A'(12'h100 + i);
            dt[i] = rr_data[i];
        end
        for (int c = 0; c < P; c++) begin
            drive(); #1;
            checks++; if (bus.req_ready !== 4'(1 << c)) begin failures++; $display("FAIL rr_write_grant got=%b exp=%b", bus.req_ready, 4'(1 << c)); end
            @(negedge clock);
            v[c] = 1'b0;
        end
        v = '1; wr = '0;
        for (int c = 0; c < 8; c++) begin
            drive(); #1;
            checks++; if (bus.req_ready !== 4'(1 << (c % P))) begin failures++; $display("FAIL rr_read_grant got=%b exp=%b", bus.req_ready, 4'(1 << (c % P))); end
            if (c > 0) begin
                checks++; if (bus.resp_valid !== 4'(1 << ((c - 1) % P))) begin failures++; $display("FAIL rr_resp_valid got=%b exp=%b", bus.resp_valid, 4'(1 << ((c - 1) % P))); end
                checks++; if (bus.resp_data !== rr_data[(c - 1) % P]) begin failures++; $display("FAIL rr_resp_data got=%h exp=%h", bus.resp_data, rr_data[(c - 1) % P]); end
            end
            @(negedge clock);
        end
        clear(); #1;
        checks++; if (bus.resp_valid !== 4'b1000) begin failures++; $display("FAIL rr_last_resp_valid got=%b exp=1000", bus.resp_valid); end
        checks++; if (bus.resp_data !== rr_data[3]) begin failures++; $display("FAIL rr_last_resp_data got=%h exp=%h", bus.resp_data, rr_data[3]); end
        @(negedge clock);
    endtask

    task automatic test_concurrent();
        do_reset();
        v[1] = 1'b1; wr[1] = 1'b1; ad[1] = 12'h020; dt[1] = 32'h12345678;
        v[3] = 1'b1; wr[3] = 1'b0; ad[3] = 12'h020;
        drive(); #1;
        checks++; if (bus.req_ready !== 4'b1010) begin failures++; $display("FAIL conc_ready got=%b exp=1010", bus.req_ready); end
        checks++; if (bus.ram_read_address !== 12'h020) begin failures++; $display("FAIL conc_rd_addr got=%h exp=020", bus.ram_read_address); end
        @(negedge clock);
        clear(); #1;
        checks++; if (bus.resp_valid !== 4'b1000) begin failures++; $display("FAIL conc_resp_valid got=%b exp=1000", bus.resp_valid); end
        checks++; if (bus.resp_data !== 32'h12345678) begin failures++; $display("FAIL conc_resp_data got=%h exp=12345678", bus.resp_data); end
        @(negedge clock);
    endtask

    task automatic test_pointer();
        do_reset();
        v[1] = 1'b1;
        drive(); #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL ptr_setup_ready got=%b exp=0010", bus.req_ready); end
        @(negedge clock);
        v[1] = 1'b0; v[0] = 1'b1;
        drive(); #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL ptr_wrap_ready got=%b exp=0001", bus.req_ready); end
        @(negedge clock);
        clear();
        repeat (3) @(negedge clock);
        v = '1;
        drive(); #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL ptr_hold_read got=%b exp=0010", bus.req_ready); end
        wr = '1;
        drive(); #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL ptr_hold_write got=%b exp=0001", bus.req_ready); end
        clear();
        @(negedge clock);
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        v[1] = 1'b1; ad[1] = 12'h010;
        drive(); #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL midrst_accept got=%b exp=0010", bus.req_ready); end
        @(posedge clock); #1;
        reset_n = 1'b0;
        clear(); #1;
        checks++; if (bus.resp_valid !== 4'b0000) begin failures++; $display("FAIL midrst_resp_async got=%b exp=0000", bus.resp_valid); end
        repeat (2) @(negedge clock);
        checks++; if (bus.resp_valid !== 4'b0000) begin failures++; $display("FAIL midrst_resp_held got=%b exp=0000", bus.resp_valid); end
        reset_n = 1'b1;
        v = '1;
        drive(); #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_ptr_cleared got=%b exp=0001", bus.req_ready); end
        clear();
        @(negedge clock);
    endtask

    task automatic test_random();
        int wp, rp, wg, rg, j, p;
        logic [P-1:0] exp_ready, exp_rv;
        logic [W-1:0] exp_rd;
        do_reset();
        wp = 0; rp = 0;
        for (int a = 0; a < 16; a++) begin
            p = a % P;
            v[p] = 1'b1; wr[p] = 1'b1; ad[p] = A'(12'h200 + a); dt[p] = $urandom;
            ref_mem[a] = dt[p];
            drive(); #1;
            checks++; if (bus.req_ready !== 4'(1 << p)) begin failures++; $display("FAIL rand_preload got=%b exp=%b", bus.req_ready, 4'(1 << p)); end
            wp = (p + 1) % P;
            @(negedge clock);
            v[p] = 1'b0;
        end
        exp_rv = '0;
        exp_rd = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < P; i++) begin
                if (!v[i] && $urandom_range(0, 9) < 6) begin
                    v[i] = 1'b1;
                    wr[i] = 1'($urandom_range(0, 1));
                    ad[i] = A'(12'h200 + $urandom_range(0, 15));
                    dt[i] = $urandom;
                end
            end
            drive(); #1;
            wg = -1; rg = -1;
            for (int k = 0; k < P; k++) begin
                j = (wp + k) % P;
                if (wg < 0 && v[j] && wr[j]) wg = j;
                j = (rp + k) % P;
                if (rg < 0 && v[j] && !wr[j]) rg = j;
            end
            exp_ready = '0;
            if (wg >= 0) exp_ready[wg] = 1'b1;
            if (rg >= 0) exp_ready[rg] = 1'b1;
            checks++; if (bus.req_ready !== exp_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, exp_ready); end
            checks++; if (bus.resp_valid !== exp_rv) begin failures++; $display("FAIL rand_resp_valid cyc=%0d got=%b exp=%b", c, bus.resp_valid, exp_rv); end
            if (exp_rv != 0) begin
                checks++; if (bus.resp_data !== exp_rd) begin failures++; $display("FAIL rand_resp_data cyc=%0d got=%h exp=%h", c, bus.resp_data, exp_rd); end
            end
            if (wg >= 0) begin
                checks++; if ({bus.ram_write_address, bus.ram_write_data} !== {ad[wg], dt[wg]}) begin failures++; $display("FAIL rand_ram_write cyc=%0d got=%h/%h exp=%h/%h", c, bus.ram_write_address, bus.ram_write_data, ad[wg], dt[wg]); end
            end
            exp_rv = '0;
            if (rg >= 0) begin
                exp_rv[rg] = 1'b1;
                exp_rd = (wg >= 0 && ad[wg] == ad[rg]) ? dt[wg] : ref_mem[ad[rg][3:0]];
                rp = (rg + 1) % P;
            end
            if (wg >= 0) begin
                ref_mem[ad[wg][3:0]] = dt[wg];
                wp = (wg + 1) % P;
            end
            @(negedge clock);
            if (wg >= 0) v[wg] = 1'b0;
            if (rg >= 0) v[rg] = 1'b0;
        end
        clear(); #1;
        checks++; if (bus.resp_valid !== exp_rv) begin failures++; $display("FAIL rand_final_resp got=%b exp=%b", bus.resp_valid, exp_rv); end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_round_robin();
        test_concurrent();
        test_pointer();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
